// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables, bubbles and flushes for the 5-stage core.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1_index,
  input  logic [4:0]  id_rs2_index,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rgD_index,
  input  logic        ex_branch_taken,
  input  logic        m_mem_req,
  input  logic        m_mem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_m_write,
  output logic        m_wb_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wait,
  output logic        halted,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam int unsigned CW_RAW = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_HALT
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt, wait_next;
  logic          load_use;
  logic          mem_stall;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_is_load && (ex_rgD_index != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1_index == ex_rgD_index)) ||
                     (id_uses_rs2 && (id_rs2_index == ex_rgD_index)));

  assign mem_stall = m_mem_req && !m_mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    ex_m_write  = 1'b1;
    m_wb_write  = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mem_wait    = 1'b0;
    state_next  = state;
    wait_next   = wait_cnt;

    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      ex_m_write  = 1'b0;
      m_wb_write  = 1'b0;
      state_next  = S_RUN;
      wait_next   = '0;
    end else begin
      case (state)
        S_RUN, S_MEM_WAIT: begin
          if (mem_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
            ex_m_write  = 1'b0;
            m_wb_write  = 1'b0;
            mem_wait    = 1'b1;
            wait_next   = wait_cnt + 1'b1;
            if (TIMEOUT_EN && (wait_cnt == LAST_WAIT))
              state_next = S_HALT;
            else
              state_next = S_MEM_WAIT;
          end else begin
            state_next = S_RUN;
            wait_next  = '0;
            // A taken branch squashes the ID instruction, so any load-use on it is moot.
            if (ex_branch_taken) begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end else if (load_use) begin
              pc_write    = 1'b0;
              if_id_write = 1'b0;
              id_ex_flush = 1'b1;
            end
          end
        end
        default: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_write = 1'b0;
          ex_m_write  = 1'b0;
          m_wb_write  = 1'b0;
          state_next  = S_HALT;
        end
      endcase
    end
  end

  assign halted = (state == S_HALT);

`ifdef PIPE_CTRL_PERF_EN
  logic load_use_bubble;

  // Only the load-use response inserts an ID/EX bubble without also flushing IF/ID.
  assign load_use_bubble = id_ex_flush && !if_id_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (mem_wait || load_use_bubble)
        stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush)
        flush_count <= flush_count + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
